// File: rtl/ssd_scan_driver_if.sv
// Purpose : bundle of the display-driver bus: capture side (value/dp_in/load/blank_lz) and pad side.
// Latency : n/a (signal bundle only).
// Backpressure: none; load is a plain capture strobe with no ready.
// Ports (master = controller driving the display, slave = ssd_scan_driver):
//   value[15:0] four hex nibbles, dp_in[3:0] decimal points (1 = lit), load capture strobe,
//   blank_lz leading-zero blanking enable, an[3:0]/seg[6:0]/dp active-low pads, frame_tick scan wrap pulse.
interface ssd_scan_driver_if;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    modport master (
        output value, dp_in, load, blank_lz,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  value, dp_in, load, blank_lz,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/ssd_scan_driver.sv
// Purpose : time-multiplexed 4-digit 7-segment scan driver with ghosting guard and leading-zero blanking.
// Latency : load/blank_lz take effect on the pads the cycle after the capturing edge; pads decode registers only.
// Backpressure: none; load is accepted on every edge it is high and never disturbs the scan timing.
// Ports: clk (rising edge), rst_n (async active-low), bus (ssd_scan_driver_if.slave):
//   value/dp_in/load/blank_lz in, an[3:0] seg[6:0] dp (all active-low) and frame_tick out.
module ssd_scan_driver #(
    parameter int DIV   = 100000,
    parameter int BLANK = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    ssd_scan_driver_if.slave  bus
);

    localparam int            PW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] prescaler;
    logic [1:0]    digit_idx;
    logic [15:0]   disp_reg;
    logic [3:0]    dp_reg;
    // blank_lz is sampled each cycle so the pads never see a combinational path from it.
    logic          lz_reg;

    logic          slot_end;
    logic          in_blank;
    logic [3:0]    nib;
    logic [3:0]    lz_mask;

    logic [3:0]    an_c;
    logic [6:0]    seg_c;
    logic          dp_c;
    logic          ft_c;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign slot_end = (prescaler == LAST);

    // Scan counters and display registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            digit_idx <= 2'd0;
            disp_reg  <= 16'h0000;
            dp_reg    <= 4'h0;
            lz_reg    <= 1'b0;
        end else begin
            if (slot_end) begin
                prescaler <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                prescaler <= prescaler + PW'(1);
            end
            if (bus.load) begin
                disp_reg <= bus.value;
                dp_reg   <= bus.dp_in;
            end
            lz_reg <= bus.blank_lz;
        end
    end

    // A zero-length guard window must not build a compare that is always false.
    generate
        if (BLANK == 0) begin : g_no_guard
            assign in_blank = 1'b0;
        end else begin : g_guard
            localparam logic [PW-1:0] BL = PW'(BLANK);
            assign in_blank = (prescaler < BL);
        end
    endgenerate

    assign nib = disp_reg[{digit_idx, 2'b00} +: 4];

    // Blanking chains downward from the top digit: digit k goes dark only if every
    // nibble from k up to 3 is zero. Digit 0 always shows something.
    assign lz_mask[3] = lz_reg && (disp_reg[15:12] == 4'h0);
    assign lz_mask[2] = lz_mask[3] && (disp_reg[11:8] == 4'h0);
    assign lz_mask[1] = lz_mask[2] && (disp_reg[7:4] == 4'h0);
    assign lz_mask[0] = 1'b0;

    // Pad decode. rst_n gates the pads directly so they are dark during reset
    // even when there is no guard window.
    always_comb begin
        an_c  = 4'hF;
        seg_c = 7'h7F;
        dp_c  = 1'b1;
        ft_c  = 1'b0;
        if (rst_n) begin
            ft_c = slot_end && (digit_idx == 2'd3);
            if (!in_blank) begin
                an_c  = ~(4'b0001 << digit_idx);
                dp_c  = ~dp_reg[digit_idx];
                seg_c = lz_mask[digit_idx] ? 7'h7F : hex_seg(nib);
            end
        end
    end

    assign bus.an         = an_c;
    assign bus.seg        = seg_c;
    assign bus.dp         = dp_c;
    assign bus.frame_tick = ft_c;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Purpose : self-checking bench for ssd_scan_driver (DIV=8, BLANK=2 and a BLANK=0 twin).
// Latency : reference model advances one step per rising edge; pads sampled 1 time unit after the edge.
// Backpressure: n/a.
module tb_ssd_scan_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ssd_scan_driver_if bus ();
    ssd_scan_driver_if bus0 ();

    assign bus0.value    = bus.value;
    assign bus0.dp_in    = bus.dp_in;
    assign bus0.load     = bus.load;
    assign bus0.blank_lz = bus.blank_lz;

    ssd_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ssd_scan_driver #(.DIV(DIV), .BLANK(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: time since reset release plus the captured display contents.
    int          mcyc;
    logic [15:0] mdisp;
    logic [3:0]  mdp;
    logic        mlz;

    logic [6:0] seg_lut [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dpi;
        logic        lz;
        int          dig;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    vec_t vt [$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, mcyc);
        end
    endtask

    // Expected pads {an, seg, dp, frame_tick} from elapsed time and display contents.
    function automatic logic [12:0] model_out(input int blank);
        int         phase;
        int         dig;
        logic [3:0] an;
        logic [6:0] seg;
        logic       d;
        logic       ft;
        logic [3:0] n;
        phase = mcyc % DIV;
        dig   = (mcyc / DIV) % 4;
        n     = 4'((mdisp >> (4 * dig)) & 16'h000F);
        ft    = (dig == 3) && (phase == DIV - 1);
        if (phase < blank) begin
            an  = 4'hF;
            seg = 7'h7F;
            d   = 1'b1;
        end else begin
            an  = ~(4'b0001 << dig);
            d   = ~mdp[dig];
            seg = (mlz && dig > 0 && (mdisp >> (4 * dig)) == 16'h0) ? 7'h7F : seg_lut[n];
        end
        return {an, seg, d, ft};
    endfunction

    task automatic check_all();
        logic [12:0] e;
        logic [12:0] e0;
        e  = model_out(BLANK);
        e0 = model_out(0);
        chk("an",          16'(bus.an),          16'(e[12:9]));
        chk("seg",         16'(bus.seg),         16'(e[8:2]));
        chk("dp",          16'(bus.dp),          16'(e[1]));
        chk("frame_tick",  16'(bus.frame_tick),  16'(e[0]));
        chk("an_b0",       16'(bus0.an),         16'(e0[12:9]));
        chk("seg_b0",      16'(bus0.seg),        16'(e0[8:2]));
        chk("dp_b0",       16'(bus0.dp),         16'(e0[1]));
        chk("frame_tick_b0", 16'(bus0.frame_tick), 16'(e0[0]));
    endtask

    task automatic check_reset_pads(input string tag);
        chk({tag, "_an"},  16'(bus.an),          16'hF);
        chk({tag, "_seg"}, 16'(bus.seg),         16'h7F);
        chk({tag, "_dp"},  16'(bus.dp),          16'h1);
        chk({tag, "_ft"},  16'(bus.frame_tick),  16'h0);
        chk({tag, "_an0"}, 16'(bus0.an),         16'hF);
        chk({tag, "_seg0"}, 16'(bus0.seg),       16'h7F);
        chk({tag, "_dp0"}, 16'(bus0.dp),         16'h1);
        chk({tag, "_ft0"}, 16'(bus0.frame_tick), 16'h0);
    endtask

    task automatic step();
        @(posedge clk);
        mcyc++;
        if (bus.load) begin
            mdisp = bus.value;
            mdp   = bus.dp_in;
        end
        mlz = bus.blank_lz;
        #1;
        check_all();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        mcyc  = 0;
        mdisp = 16'h0;
        mdp   = 4'h0;
        mlz   = 1'b0;
        #1;
        check_all();
    endtask

    // Advance until the model sits at the given digit/phase, bounded to two frames.
    task automatic wait_slot(input int dig, input int ph);
        int n;
        n = 0;
        while ((mcyc % (4 * DIV)) != (dig * DIV + ph) && n < 64) begin
            step();
            n++;
        end
        if ((mcyc % (4 * DIV)) != (dig * DIV + ph)) begin
            checks++;
            failures++;
            $display("FAIL wait_slot timeout: got cycle %0d required slot %0d phase %0d", mcyc, dig, ph);
        end
    endtask

    task automatic load_pulse(input logic [15:0] v, input logic [3:0] d);
        bus.value = v;
        bus.dp_in = d;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
    endtask

    initial begin
        int ft_cnt;
        int ft_first;

        vt.push_back('{16'h12AF, 4'b0100, 1'b0, 0, 7'b0001110, 1'b1});
        vt.push_back('{16'h12AF, 4'b0100, 1'b0, 1, 7'b0001000, 1'b1});
        vt.push_back('{16'h12AF, 4'b0100, 1'b0, 2, 7'b0100100, 1'b0});
        vt.push_back('{16'h12AF, 4'b0100, 1'b0, 3, 7'b1111001, 1'b1});
        vt.push_back('{16'h0005, 4'b0000, 1'b1, 3, 7'b1111111, 1'b1});
        vt.push_back('{16'h0005, 4'b0000, 1'b1, 2, 7'b1111111, 1'b1});
        vt.push_back('{16'h0005, 4'b0000, 1'b1, 1, 7'b1111111, 1'b1});
        vt.push_back('{16'h0005, 4'b0000, 1'b1, 0, 7'b0010010, 1'b1});
        vt.push_back('{16'h0005, 4'b0000, 1'b0, 1, 7'b1000000, 1'b1});
        vt.push_back('{16'h0005, 4'b0000, 1'b0, 3, 7'b1000000, 1'b1});
        vt.push_back('{16'h0300, 4'b0000, 1'b1, 3, 7'b1111111, 1'b1});
        vt.push_back('{16'h0300, 4'b0000, 1'b1, 2, 7'b0110000, 1'b1});
        vt.push_back('{16'h0300, 4'b0000, 1'b1, 1, 7'b1000000, 1'b1});
        vt.push_back('{16'h6789, 4'b0000, 1'b0, 0, 7'b0010000, 1'b1});
        vt.push_back('{16'h6789, 4'b0000, 1'b0, 1, 7'b0000000, 1'b1});
        vt.push_back('{16'h6789, 4'b0000, 1'b0, 2, 7'b1111000, 1'b1});
        vt.push_back('{16'h6789, 4'b0000, 1'b0, 3, 7'b0000010, 1'b1});
        vt.push_back('{16'hBCDE, 4'b0000, 1'b0, 0, 7'b0000110, 1'b1});
        vt.push_back('{16'hBCDE, 4'b0000, 1'b0, 1, 7'b0100001, 1'b1});
        vt.push_back('{16'hBCDE, 4'b0000, 1'b0, 2, 7'b1000110, 1'b1});
        vt.push_back('{16'hBCDE, 4'b0000, 1'b0, 3, 7'b0000011, 1'b1});
        vt.push_back('{16'h4000, 4'b1000, 1'b1, 3, 7'b0011001, 1'b0});
        vt.push_back('{16'h0000, 4'b0001, 1'b1, 0, 7'b1000000, 1'b0});
        vt.push_back('{16'h0000, 4'b0000, 1'b1, 2, 7'b1111111, 1'b1});

        bus.value    = 16'h0;
        bus.dp_in    = 4'h0;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
        mcyc  = 0;
        mdisp = 16'h0;
        mdp   = 4'h0;
        mlz   = 1'b0;

        // Reset state, then idle scan pattern and frame tick cadence.
        #13;
        check_reset_pads("reset");
        release_reset();
        ft_cnt   = 0;
        ft_first = -1;
        for (int i = 0; i < 64; i++) begin
            step();
            if (mcyc == 2) chk("idle_an_d0", 16'(bus.an), 16'hE);
            if (mcyc == 1) chk("idle_guard_an", 16'(bus.an), 16'hF);
            if (bus.frame_tick) begin
                ft_cnt++;
                if (ft_first < 0) ft_first = mcyc;
            end
        end
        chk("frame_tick_count", 16'(ft_cnt), 16'd2);
        chk("frame_tick_first", 16'(ft_first), 16'd31);

        // Table of display contents versus expected pad decode.
        foreach (vt[i]) begin
            bus.blank_lz = vt[i].lz;
            load_pulse(vt[i].value, vt[i].dpi);
            wait_slot(vt[i].dig, BLANK);
            chk($sformatf("tbl%0d_seg", i),  16'(bus.seg),  16'(vt[i].seg));
            chk($sformatf("tbl%0d_dp", i),   16'(bus.dp),   16'(vt[i].dp));
            chk($sformatf("tbl%0d_seg0", i), 16'(bus0.seg), 16'(vt[i].seg));
        end

        // blank_lz toggle takes effect the following cycle.
        bus.blank_lz = 1'b1;
        load_pulse(16'h0005, 4'h0);
        wait_slot(1, 3);
        chk("lz_on_seg", 16'(bus.seg), 16'h7F);
        bus.blank_lz = 1'b0;
        step();
        chk("lz_off_seg", 16'(bus.seg), 16'b1000000);
        chk("lz_off_an",  16'(bus.an),  16'b1101);

        // Mid-slot load in digit 2: scan continues, new nibble shows next cycle.
        wait_slot(2, 4);
        load_pulse(16'h0C00, 4'h0);
        chk("midload_seg", 16'(bus.seg), 16'b1000110);
        chk("midload_an",  16'(bus.an),  16'b1011);
        step();
        chk("midload_an_next", 16'(bus.an), 16'b1011);

        // Asynchronous reset in the middle of digit 3.
        wait_slot(3, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_pads("async_rst");
        @(negedge clk);
        @(negedge clk);
        check_reset_pads("rst_hold");
        bus.blank_lz = 1'b0;
        release_reset();
        wait_slot(0, 2);
        chk("post_rst_an_d0",  16'(bus.an),  16'hE);
        chk("post_rst_seg_d0", 16'(bus.seg), 16'b1000000);
        wait_slot(1, 2);
        chk("post_rst_an_d1",  16'(bus.an),  16'hD);
        chk("post_rst_seg_d1", 16'(bus.seg), 16'b1000000);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] mask;
            case ($urandom_range(0, 4))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            bus.value = 16'($urandom) & mask;
            bus.dp_in = 4'($urandom);
            bus.load  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) bus.blank_lz = ~bus.blank_lz;
            step();
        end
        bus.load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ssd_scan_driver.md
SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, as listed below.
REQ-002 Parameter DIV, default 100000, SHALL set the clock cycles each digit is selected (1 ms at 100 MHz); legal range DIV >= 2.
REQ-003 Parameter BLANK, default 1000, SHALL set the cycles at the start of each digit slot during which all anodes are off (ghosting guard); legal range 0 <= BLANK < DIV.
REQ-004 Ports SHALL be, one per line:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- value  input  16  four hex nibbles; digit k shows value[4k+3:4k]
- dp_in  input  4  decimal points, bit k for digit k, 1 = lit
- load  input  1  capture strobe for value and dp_in
- blank_lz  input  1  1 = enable leading-zero blanking
- an  output  4  anode selects, active-low, bit k = digit k
- seg  output  7  segments {g,f,e,d,c,b,a} = seg[6:0], active-low
- dp  output  1  decimal point, active-low
- frame_tick  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0

Function
REQ-005 The block SHALL hold registered state: disp_reg[15:0], dp_reg[3:0], prescaler (0..DIV-1), digit_idx (0..3).
REQ-006 When load = 1 at a rising edge, disp_reg <= value and dp_reg <= dp_in; otherwise both hold.
REQ-007 The new contents SHALL be visible on seg/dp from the cycle after capture; load SHALL NOT disturb prescaler or digit_idx.
REQ-008 Each cycle, if prescaler = DIV-1 then prescaler <= 0 and digit_idx <= (digit_idx+1) mod 4; otherwise prescaler <= prescaler+1.
REQ-009 Scan order SHALL be 0,1,2,3,0,...; each digit is selected for exactly DIV cycles.
REQ-010 frame_tick SHALL be 1 on exactly the one cycle where digit_idx = 3 and prescaler = DIV-1; otherwise 0.
REQ-011 an, seg and dp SHALL be combinational decodes of the registered state only, with no combinational path from value, dp_in, load or blank_lz.
REQ-012 If prescaler < BLANK: an = 1111, seg = 1111111, dp = 1.
REQ-013 Otherwise an SHALL drive only bit digit_idx low (digit 0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111).
REQ-014 seg SHALL be the active-low hex decode of the selected nibble: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-015 dp SHALL be ~dp_reg[digit_idx] outside the blank window.
REQ-016 Leading-zero blanking: when blank_lz = 1, digit k (k = 3, 2, 1) SHALL be blanked if disp_reg nibbles k..3 are all zero; digit 0 is never blanked.
REQ-017 A blanked digit SHALL drive seg = 1111111; its anode and dp SHALL still follow REQ-013 and REQ-015.
REQ-018 blank_lz SHALL be evaluated live against disp_reg (no capture needed).
REQ-019 With BLANK = 0 there SHALL be no blank window; an is never 1111 after reset.

Reset
REQ-020 While rst_n = 0, independent of clk: disp_reg = 0, dp_reg = 0, prescaler = 0, digit_idx = 0.
REQ-021 While rst_n = 0 the outputs SHALL be forced an = 1111, seg = 1111111, dp = 1, frame_tick = 0, regardless of BLANK.
REQ-022 Reset asserted mid-scan SHALL abort the scan immediately.
REQ-023 After release, the first rising edge SHALL start counting from prescaler = 0, digit_idx = 0.

Verification (DIV = 8, BLANK = 2)
REQ-024 Reset then idle -> an pattern per slot: 1111 for 2 cycles, then 1110 for 6; then 1111 for 2, 1101 for 6; then 1011, then 0111; frame_tick high exactly once every 32 cycles, on the last cycle of digit 3.
REQ-025 load with value = 16'h12AF, dp_in = 0100 -> digit 0 seg = 0001110 (F), digit 1 = 0001000 (A), digit 2 = 0100100 (2) with dp = 0, digit 3 = 1111001 (1); all other dp = 1.
REQ-026 value = 16'h0005, blank_lz = 1 -> digits 3, 2, 1 show seg = 1111111 with anodes still cycling; digit 0 shows 0010010. Toggle blank_lz to 0 -> digits 1-3 show 1000000 from the next cycle.
REQ-027 load pulsed mid-slot of digit 2 -> prescaler and digit_idx sequence unchanged; seg switches to the new nibble on the following cycle.
REQ-028 rst_n pulled low mid-slot of digit 3, asynchronous to clk -> an = 1111 and seg = 1111111 immediately; after release the scan restarts at digit 0 with display contents 0000.
REQ-029 BLANK = 0, value = 16'h0000, blank_lz = 1 -> an is never 1111; digits 1-3 are blank; digit 0 shows 1000000.
